load_hazard_scoreboard: RTL and testbench

Parametrised load-use hazard unit for the in-order RISC-V pipeline. It replaces the fixed single-bubble detector in the ID stage and supports data memories whose load data becomes forwardable `LAT` cycles after the load leaves ID. It tracks in-flight loads in a `LAT`-deep shift scoreboard and stalls the ID instruction until every source register it reads is available. It honours a global memory freeze and a branch flush, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/load_hazard_scoreboard.sv | 85 ++++++++
 tb/tb_load_hazard_scoreboard.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit: a LAT-deep shift scoreboard of in-flight load destinations,
// stalling ID (combinationally) until every source it reads is forwardable.
module load_hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_valid_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic              RS1use_i,
  input  logic              RS2use_i,
  input  logic              ID_MemRead_i,
  input  logic [ADDR_W-1:0] ID_RDaddr_i,
  input  logic              Mem_stall_i,
  input  logic              Flush_i,
  input  logic              Cnt_clr_i,
  output logic              NoOp_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
  output logic [1:0]        Hazard_src_o,
  output logic [CNT_W-1:0]  Stall_count_o
);

  logic              sb_valid [LAT];
  logic [ADDR_W-1:0] sb_rd    [LAT];
  logic              hit1;
  logic              hit2;
  logic              m1;
  logic              m2;
  logic              live;
  logic              hazard;
  logic              issue;

  // Stage 0 is the youngest load; any valid stage with a matching rd blocks the reader.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (sb_valid[k] && (sb_rd[k] == RS1addr_i)) hit1 = 1'b1;
      if (sb_valid[k] && (sb_rd[k] == RS2addr_i)) hit2 = 1'b1;
    end
  end

  assign m1     = hit1 & RS1use_i & (RS1addr_i != '0);
  assign m2     = hit2 & RS2use_i & (RS2addr_i != '0);
  assign live   = ID_valid_i & ~Flush_i;
  assign hazard = live & (m1 | m2);
  assign issue  = live & ID_MemRead_i & (ID_RDaddr_i != '0) & ~hazard;

  assign Stall_o      = hazard;
  assign NoOp_o       = hazard;
  assign PCWrite_o    = ~hazard;
  assign Hazard_src_o = {m2 & live, m1 & live};

  // A frozen pipeline holds the scoreboard so every pending stall stretches with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < LAT; k++) begin
        sb_valid[k] <= 1'b0;
        sb_rd[k]    <= '0;
      end
    end else if (!Mem_stall_i) begin
      for (int k = LAT - 1; k > 0; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
      sb_valid[0] <= issue;
      sb_rd[0]    <= ID_RDaddr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Stall_count_o <= '0;
    end else if (Cnt_clr_i) begin
      Stall_count_o <= '0;
    end else if (hazard && (Stall_count_o != {CNT_W{1'b1}})) begin
      Stall_count_o <= Stall_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: three instances (LAT=1/2/3, middle one with a
// 4-bit counter) share one stimulus stream and are checked against a load-lifetime model.
module tb_load_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       u1;
  logic       u2;
  logic       mem_read;
  logic [4:0] rd;
  logic       ms;
  logic       fl;
  logic       clr;

  logic        noop_w [3];
  logic        stall_w[3];
  logic        pcw_w  [3];
  logic [1:0]  src_w  [3];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [15:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;

  load_hazard_scoreboard #(.ADDR_W(5), .LAT(1), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .ID_valid_i(id_valid), .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(u1), .RS2use_i(u2), .ID_MemRead_i(mem_read), .ID_RDaddr_i(rd),
    .Mem_stall_i(ms), .Flush_i(fl), .Cnt_clr_i(clr), .NoOp_o(noop_w[0]), .Stall_o(stall_w[0]),
    .PCWrite_o(pcw_w[0]), .Hazard_src_o(src_w[0]), .Stall_count_o(cnt0));

  load_hazard_scoreboard #(.ADDR_W(5), .LAT(2), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .ID_valid_i(id_valid), .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(u1), .RS2use_i(u2), .ID_MemRead_i(mem_read), .ID_RDaddr_i(rd),
    .Mem_stall_i(ms), .Flush_i(fl), .Cnt_clr_i(clr), .NoOp_o(noop_w[1]), .Stall_o(stall_w[1]),
    .PCWrite_o(pcw_w[1]), .Hazard_src_o(src_w[1]), .Stall_count_o(cnt1));

  load_hazard_scoreboard #(.ADDR_W(5), .LAT(3), .CNT_W(16)) dut2 (
    .clk_i(clk), .rst_i(rst), .ID_valid_i(id_valid), .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(u1), .RS2use_i(u2), .ID_MemRead_i(mem_read), .ID_RDaddr_i(rd),
    .Mem_stall_i(ms), .Flush_i(fl), .Cnt_clr_i(clr), .NoOp_o(noop_w[2]), .Stall_o(stall_w[2]),
    .PCWrite_o(pcw_w[2]), .Hazard_src_o(src_w[2]), .Stall_count_o(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each issued load is a (rd, cycles-left-visible) record; unfrozen edges age it.
  int         lat_of[3] = '{1, 2, 3};
  int         cmax  [3] = '{65535, 15, 65535};
  logic [4:0] m_rd  [3][8];
  int         m_rem [3][8];
  int         m_cnt [3];
  int         obs_total[3] = '{0, 0, 0};
  int         snap[3];

  function automatic logic m_match(int i, logic [4:0] a, logic u);
    if (!u || a == 5'd0) return 1'b0;
    for (int k = 0; k < 8; k++)
      if (m_rem[i][k] > 0 && m_rd[i][k] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_live();
    return id_valid && !fl;
  endfunction

  function automatic logic m_haz(int i);
    return m_live() && (m_match(i, rs1, u1) || m_match(i, rs2, u2));
  endfunction

  function automatic logic m_issue(int i);
    return m_live() && mem_read && rd != 5'd0 && !m_haz(i);
  endfunction

  function automatic logic [31:0] dut_cnt(int i);
    if (i == 0) return {16'd0, cnt0};
    if (i == 1) return {28'd0, cnt1};
    return {16'd0, cnt2};
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
          m_rem[i][k] = 0;
          m_rd[i][k]  = 5'd0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clr) m_cnt[i] = 0;
        else if (m_haz(i) && m_cnt[i] < cmax[i]) m_cnt[i]++;
        if (!ms) begin
          if (m_issue(i)) begin
            for (int k = 0; k < 8; k++) if (m_rem[i][k] > 0) m_rem[i][k]--;
            for (int k = 0; k < 8; k++) begin
              if (m_rem[i][k] == 0) begin
                m_rem[i][k] = lat_of[i];
                m_rd[i][k]  = rd;
                break;
              end
            end
          end else begin
            for (int k = 0; k < 8; k++) if (m_rem[i][k] > 0) m_rem[i][k]--;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("noop",  i, {31'd0, noop_w[i]},  {31'd0, m_haz(i)});
      chk("stall", i, {31'd0, stall_w[i]}, {31'd0, m_haz(i)});
      chk("pcw",   i, {31'd0, pcw_w[i]},   {31'd0, !m_haz(i)});
      chk("src",   i, {30'd0, src_w[i]},
          {30'd0, m_live() && m_match(i, rs2, u2), m_live() && m_match(i, rs1, u1)});
      chk("cnt",   i, dut_cnt(i), m_cnt[i]);
      if (stall_w[i] === 1'b1) obs_total[i]++;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_id(logic v, logic [4:0] a1, logic e1, logic [4:0] a2, logic e2,
                        logic mr, logic [4:0] d);
    id_valid = v; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2; mem_read = mr; rd = d;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    ms = 1'b0; fl = 1'b0; clr = 1'b0;
  endtask

  task automatic clear_cnt();
    idle();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) snap[i] = obs_total[i];
  endtask

  task automatic load(logic [4:0] d);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, d);
    step(1);
  endtask

  task automatic expect_stalls(string name, int e0, int e1, int e2);
    int e[3];
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++) chk(name, i, obs_total[i] - snap[i], e[i]);
  endtask

  task automatic expect_cnt(string name, int e0, int e1, int e2);
    int e[3];
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++) chk(name, i, dut_cnt(i), e[i]);
  endtask

  task automatic expect_quiet(string name);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_stall"}, i, {31'd0, stall_w[i]}, 32'd0);
      chk({name, "_noop"},  i, {31'd0, noop_w[i]},  32'd0);
      chk({name, "_pcw"},   i, {31'd0, pcw_w[i]},   32'd1);
      chk({name, "_src"},   i, {30'd0, src_w[i]},   32'd0);
      chk({name, "_cnt"},   i, dut_cnt(i),          32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2 rst = 1'b1;
    #1 expect_quiet("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);
    expect_quiet("post_rst");

    // lw x5; add x6,x5,x7 right behind
    clear_cnt();
    load(5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 5'd6);
    #1;
    for (int i = 0; i < 3; i++) chk("adj_src", i, {30'd0, src_w[i]}, 32'd1);
    step(5);
    expect_stalls("adj_stalls", 1, 2, 3);
    expect_cnt("adj_cnt", 1, 2, 3);
    idle(); step(4);

    // lw x5; nop; add x1,x2,x5
    clear_cnt();
    load(5'd5);
    idle(); step(1);
    set_id(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 5'd1);
    #1;
    chk("gap_src", 0, {30'd0, src_w[0]}, 32'd0);
    chk("gap_src", 1, {30'd0, src_w[1]}, 32'd2);
    chk("gap_src", 2, {30'd0, src_w[2]}, 32'd2);
    step(5);
    expect_stalls("gap_stalls", 0, 1, 2);
    idle(); step(4);

    // lw x0 then a reader of x0
    clear_cnt();
    load(5'd0);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd3);
    step(5);
    expect_stalls("x0_stalls", 0, 0, 0);
    idle(); step(4);

    // lw x5; consumer names x5 only on an unused RS2
    clear_cnt();
    load(5'd5);
    set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd3);
    step(5);
    expect_stalls("unused_stalls", 0, 0, 0);
    idle(); step(4);

    // lw x5; dependent consumer flushed for 2 cycles, then live
    clear_cnt();
    load(5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3);
    fl = 1'b1;
    step(2);
    fl = 1'b0;
    step(4);
    expect_stalls("flush_stalls", 0, 0, 1);
    idle(); step(4);

    // lw x5; dependent consumer with 2 frozen cycles at its start
    clear_cnt();
    load(5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6);
    ms = 1'b1;
    step(2);
    ms = 1'b0;
    step(4);
    expect_stalls("freeze_stalls", 3, 4, 5);
    expect_cnt("freeze_cnt", 3, 4, 5);
    idle(); step(4);

    // 20 frozen stall cycles saturate the 4-bit counter; clear wins over a stall
    clear_cnt();
    load(5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6);
    ms = 1'b1;
    step(20);
    expect_stalls("sat_stalls", 20, 20, 20);
    expect_cnt("sat_cnt", 20, 15, 20);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    expect_cnt("clr_cnt", 0, 0, 0);
    ms = 1'b0;
    step(4);
    idle(); step(4);

    // reset asserted in the middle of a stall
    clear_cnt();
    load(5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6);
    for (int i = 0; i < 3; i++) snap[i] = obs_total[i];
    #2 rst = 1'b1;
    #1 expect_quiet("rst_mid");
    rst = 1'b0;
    step(3);
    expect_stalls("rst_stalls", 0, 0, 0);
    idle(); step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
